// File: rtl/serial_pkg.sv
// serial_pkg
//   Register map and status bit positions shared by the serial port
//   (addresses 8/9) and the receive FIFO (addresses 10..12).
//   No ports.
package serial_pkg;

  // I/O window register addresses
  localparam logic [3:0] SER_STAT = 4'd8;
  localparam logic [3:0] SER_DATA = 4'd9;
  localparam logic [3:0] RXF_STAT = 4'd10;
  localparam logic [3:0] RXF_DATA = 4'd11;
  localparam logic [3:0] RXF_CNT  = 4'd12;

  // RXF_STAT read bit positions
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_INTR_EN   = 3;
  localparam int ST_RTS_N     = 4;

  // RXF_STAT write bit positions
  localparam int CTL_INTR_EN  = 0;
  localparam int CTL_CLR_OVR  = 1;
  localparam int CTL_FLUSH    = 2;

  // True for the three addresses owned by the receive FIFO
  function automatic logic is_rxf_addr(input logic [3:0] a);
    return (a == RXF_STAT) || (a == RXF_DATA) || (a == RXF_CNT);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with push, pop and flush.
//   Ports:
//     cpuclk, rst      clock, asynchronous active-high reset
//     push, din        write request and data
//     pop              read request (ignored when empty)
//     flush            empties the FIFO; overrides push and pop
//     dout             word at the read pointer (valid when !empty)
//     full, empty      occupancy flags
//     count            current occupancy, 0..2^DEPTH_LOG2
//     count_next       occupancy after this cycle's update
//     overflow         push refused because the FIFO was full
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  cpuclk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   count_next,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still succeeds when it coincides with a pop.
  assign do_pop   = pop && !empty && !flush;
  assign do_push  = push && (!full || do_pop) && !flush;
  assign overflow = push && !do_push && !flush;

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (do_pop && !do_push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge cpuclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo
//   Receive byte buffer between the serial receiver and the Z80 bus, with
//   RTS hysteresis flow control and a data-available interrupt.
//   Ports:
//     cpuclk              4 MHz system clock
//     rst                 asynchronous active-high reset
//     rx_byte, rx_strobe  received byte, one-cycle valid pulse
//     data                Z80 data bus, driven only during a decoded read
//     ncs, nrd, nwr       chip select / read / write strobes, active low
//     addr                register address (10 status, 11 data, 12 count)
//     rts_n               flow control to remote end, low = may send
//     intr_out            interrupt request, high while enabled and not empty
//   Bus handshake: a read or write is one strobe (rd/wr held for any number
//   of cycles); the side effect (pop or register write) happens exactly once
//   per strobe, guarded by got_rd/got_wr.
module serial_rx_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int RTS_HIGH   = 12,
  parameter int RTS_LOW    = 4
) (
  input  logic       cpuclk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_strobe,
  inout  wire  [7:0] data,
  input  logic       ncs,
  input  logic       nrd,
  input  logic       nwr,
  input  logic [3:0] addr,
  output logic       rts_n,
  output logic       intr_out
);

  localparam logic [DEPTH_LOG2:0] RTS_HIGH_C = (DEPTH_LOG2 + 1)'(RTS_HIGH);
  localparam logic [DEPTH_LOG2:0] RTS_LOW_C  = (DEPTH_LOG2 + 1)'(RTS_LOW);

  logic                sel, rd, wr;
  logic                got_rd, got_wr;
  logic [3:0]          rd_addr;
  logic                wr_fire, ctl_wr;
  logic                pop, flush;
  logic                overrun, intr_en;
  logic [7:0]          rd_data;
  logic [7:0]          dout;
  logic                full, empty, overflow;
  logic [DEPTH_LOG2:0] count, count_next;

  assign sel = !ncs && is_rxf_addr(addr);
  assign rd  = sel && !nrd;
  assign wr  = sel && !nwr;

  // Pop on the first idle cycle after a data read ends, so a long strobe
  // still yields exactly one pop and the CPU saw the pre-pop byte.
  assign pop = got_rd && !rd && (rd_addr == RXF_DATA);

  // Writes act on the first cycle of the strobe while data is valid.
  assign wr_fire = wr && !got_wr;
  assign ctl_wr  = wr_fire && (addr == RXF_STAT);
  assign flush   = ctl_wr && data[CTL_FLUSH];

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .cpuclk     (cpuclk),
    .rst        (rst),
    .push       (rx_strobe),
    .pop        (pop),
    .flush      (flush),
    .din        (rx_byte),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .count_next (count_next),
    .overflow   (overflow)
  );

  // Bus strobe edge guards
  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      got_rd  <= 1'b0;
      got_wr  <= 1'b0;
      rd_addr <= '0;
    end else begin
      got_wr <= wr;
      if (rd) begin
        got_rd  <= 1'b1;
        rd_addr <= addr;
      end else if (got_rd) begin
        got_rd <= 1'b0;
      end
    end
  end

  // Control/status registers, RTS hysteresis and interrupt
  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      intr_en  <= 1'b0;
      overrun  <= 1'b0;
      rts_n    <= 1'b1;
      intr_out <= 1'b0;
    end else begin
      if (ctl_wr) intr_en <= data[CTL_INTR_EN];

      if (overflow)
        overrun <= 1'b1;
      else if (ctl_wr && data[CTL_CLR_OVR])
        overrun <= 1'b0;

      // Between the thresholds rts_n holds its previous value.
      if (count_next >= RTS_HIGH_C)
        rts_n <= 1'b1;
      else if (count_next <= RTS_LOW_C)
        rts_n <= 1'b0;

      intr_out <= intr_en && !empty;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      RXF_STAT: begin
        rd_data[ST_NOT_EMPTY] = !empty;
        rd_data[ST_FULL]      = full;
        rd_data[ST_OVERRUN]   = overrun;
        rd_data[ST_INTR_EN]   = intr_en;
        rd_data[ST_RTS_N]     = rts_n;
      end
      RXF_DATA: rd_data = empty ? 8'h00 : dout;
      RXF_CNT:  rd_data[DEPTH_LOG2:0] = count;
      default:  rd_data = '0;
    endcase
  end

  assign data = rd ? rd_data : 8'hzz;

endmodule

// File: tb/tb_serial_rx_fifo.sv
module tb_serial_rx_fifo;

  logic       cpuclk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_strobe = 1'b0;
  logic       ncs = 1'b1;
  logic       nrd = 1'b1;
  logic       nwr = 1'b1;
  logic [3:0] addr = 4'd0;
  wire  [7:0] data;
  wire        rts_n;
  wire        intr_out;
  logic [7:0] drv_val = 8'h00;
  logic       drv_en = 1'b0;

  assign data = drv_en ? drv_val : 8'hzz;

  serial_rx_fifo dut (
    .cpuclk    (cpuclk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .data      (data),
    .ncs       (ncs),
    .nrd       (nrd),
    .nwr       (nwr),
    .addr      (addr),
    .rts_n     (rts_n),
    .intr_out  (intr_out)
  );

  // ---------------- clock ----------------
  always #5 cpuclk = ~cpuclk;

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs change on negedge; DUT state is sampled on negedge after the edge.
  task automatic bus_read(input logic [3:0] a, input int len, input bit with_push,
                          input logic [7:0] pb, output logic [7:0] val);
    @(negedge cpuclk);
    addr = a; ncs = 1'b0; nrd = 1'b0;
    repeat (len) @(negedge cpuclk);
    val = data;
    ncs = 1'b1; nrd = 1'b1;
    if (with_push) begin
      rx_byte = pb; rx_strobe = 1'b1;
    end
    @(negedge cpuclk);
    rx_strobe = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d,
                           input bit with_push, input logic [7:0] pb);
    @(negedge cpuclk);
    addr = a; ncs = 1'b0; nwr = 1'b0; drv_val = d; drv_en = 1'b1;
    if (with_push) begin
      rx_byte = pb; rx_strobe = 1'b1;
    end
    @(negedge cpuclk);
    rx_strobe = 1'b0;
    @(negedge cpuclk);
    ncs = 1'b1; nwr = 1'b1; drv_en = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge cpuclk);
    rx_byte = b; rx_strobe = 1'b1;
    @(negedge cpuclk);
    rx_strobe = 1'b0;
    if (exp_q.size() < 16) exp_q.push_back(b);
  endtask

  task automatic read_data(input string name, input int len);
    logic [7:0] v, e;
    bus_read(4'd11, len, 1'b0, 8'h00, v);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check(name, v, e);
  endtask

  // Data read whose pop coincides with an incoming byte
  task automatic read_data_push(input string name, input logic [7:0] pb);
    logic [7:0] v, e;
    bus_read(4'd11, 1, 1'b1, pb, v);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    if (exp_q.size() < 16) exp_q.push_back(pb);
    check(name, v, e);
  endtask

  task automatic expect_reg(input string name, input logic [3:0] a, input logic [7:0] e);
    logic [7:0] v;
    bus_read(a, 1, 1'b0, 8'h00, v);
    check(name, v, e);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         op;    // 0 push, 1 read and compare, 2 write
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [7:0] v;

    vecs[0]  = '{0, 4'd0,  8'h41, 8'h00, "push41"};
    vecs[1]  = '{0, 4'd0,  8'h42, 8'h00, "push42"};
    vecs[2]  = '{0, 4'd0,  8'h43, 8'h00, "push43"};
    vecs[3]  = '{1, 4'd10, 8'h00, 8'h01, "stat3"};
    vecs[4]  = '{1, 4'd12, 8'h00, 8'h03, "cnt3"};
    vecs[5]  = '{1, 4'd11, 8'h00, 8'h41, "rd41"};
    vecs[6]  = '{1, 4'd11, 8'h00, 8'h42, "rd42"};
    vecs[7]  = '{1, 4'd11, 8'h00, 8'h43, "rd43"};
    vecs[8]  = '{1, 4'd12, 8'h00, 8'h00, "cnt0"};
    vecs[9]  = '{1, 4'd10, 8'h00, 8'h00, "stat_empty"};
    vecs[10] = '{1, 4'd11, 8'h00, 8'h00, "rd_empty"};
    vecs[11] = '{1, 4'd12, 8'h00, 8'h00, "cnt_after_empty_rd"};
    vecs[12] = '{2, 4'd11, 8'h07, 8'h00, "wr11_ignored"};
    vecs[13] = '{1, 4'd10, 8'h00, 8'h00, "stat_after_wr11"};

    // reset state
    @(negedge cpuclk);
    check("reset_rts_n", {7'd0, rts_n}, 8'h01);
    check("reset_intr", {7'd0, intr_out}, 8'h00);
    rst = 1'b0;
    @(negedge cpuclk);
    check("rts_after_release", {7'd0, rts_n}, 8'h00);

    // basic push/read table
    foreach (vecs[i]) begin
      case (vecs[i].op)
        0: push_byte(vecs[i].d);
        1: begin
          bus_read(vecs[i].a, 1, 1'b0, 8'h00, v);
          if (vecs[i].a == 4'd11 && exp_q.size() > 0) void'(exp_q.pop_front());
          check(vecs[i].name, v, vecs[i].exp);
        end
        default: bus_write(vecs[i].a, vecs[i].d, 1'b0, 8'h00);
      endcase
    end

    // overflow: 16 bytes then one dropped
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    push_byte(8'hAA);
    expect_reg("stat_full_ovr", 4'd10, 8'h17);
    expect_reg("cnt_full", 4'd12, 8'h10);
    for (int i = 0; i < 16; i++) read_data("drain_ovr", 1);
    expect_reg("stat_ovr_empty", 4'd10, 8'h04);
    bus_write(4'd10, 8'h02, 1'b0, 8'h00);
    expect_reg("stat_ovr_cleared", 4'd10, 8'h00);

    // RTS hysteresis
    for (int i = 0; i < 11; i++) push_byte(8'h80 + 8'(i));
    check("rts_at_11", {7'd0, rts_n}, 8'h00);
    push_byte(8'h8B);
    check("rts_at_12", {7'd0, rts_n}, 8'h01);
    for (int i = 0; i < 7; i++) read_data("rts_pop", 1);
    check("rts_at_5", {7'd0, rts_n}, 8'h01);
    read_data("rts_pop4", 1);
    check("rts_at_4", {7'd0, rts_n}, 8'h00);
    for (int i = 0; i < 4; i++) read_data("rts_drain", 1);

    // push coincident with pop while full
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    read_data_push("full_pop_push", 8'h55);
    expect_reg("stat_full_no_ovr", 4'd10, 8'h13);
    expect_reg("cnt_full_pp", 4'd12, 8'h10);
    for (int i = 0; i < 16; i++) read_data("drain_pp", 1);
    expect_reg("stat_pp_empty", 4'd10, 8'h00);

    // interrupt timing and long read strobe
    bus_write(4'd10, 8'h01, 1'b0, 8'h00);
    expect_reg("stat_intr_en", 4'd10, 8'h08);
    push_byte(8'h77);
    check("intr_same_cycle", {7'd0, intr_out}, 8'h00);
    @(negedge cpuclk);
    check("intr_next_cycle", {7'd0, intr_out}, 8'h01);
    push_byte(8'h78);
    read_data("long_read", 6);
    expect_reg("cnt_after_long", 4'd12, 8'h01);
    read_data("rd78", 1);
    @(negedge cpuclk);
    check("intr_cleared", {7'd0, intr_out}, 8'h00);

    // flush coincident with push
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
    bus_write(4'd10, 8'h04, 1'b1, 8'h99);
    exp_q.delete();
    expect_reg("stat_flush", 4'd10, 8'h00);
    expect_reg("cnt_flush", 4'd12, 8'h00);
    read_data("rd_after_flush", 1);
    expect_reg("cnt_after_flush_rd", 4'd12, 8'h00);

    // reset in the middle of a data read
    bus_write(4'd10, 8'h01, 1'b0, 8'h00);
    push_byte(8'hC1);
    push_byte(8'hC2);
    @(negedge cpuclk);
    addr = 4'd11; ncs = 1'b0; nrd = 1'b0;
    @(negedge cpuclk);
    #2 rst = 1'b1;
    #1 check("rst_async_rts", {7'd0, rts_n}, 8'h01);
    check("rst_async_intr", {7'd0, intr_out}, 8'h00);
    ncs = 1'b1; nrd = 1'b1;
    @(negedge cpuclk);
    rst = 1'b0;
    exp_q.delete();
    expect_reg("stat_after_rst", 4'd10, 8'h00);
    expect_reg("cnt_after_rst", 4'd12, 8'h00);
    read_data("rd_after_rst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
